ahb_ram_slave_if: RTL and testbench

AHB-Lite slave front-end placed directly upstream of the byte-addressed data RAM. It accepts pipelined AHB address/data phases and converts each valid transfer into the RAM's single-cycle strobes (sel_1, rd_en_ram, wr_en_ram, address_ram, hsize, is_signed, wr_data). Writes complete with zero wait states. Reads insert exactly one wait state to cover the RAM's registered rd_data. Out-of-range and unsupported-size transfers get the standard two-cycle ERROR response and never reach the RAM.

---
 rtl/ahb_pkg.sv | 44 ++++
 rtl/ahb_addr_check.sv | 33 +++
 rtl/ahb_ram_slave_if.sv | 114 +++++++++++
 tb/tb_ahb_ram_slave_if.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the RAM slave state enumeration.
// Used by ahb_ram_slave_if and ahb_addr_check.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_ISSUE,
    ST_RD_DONE,
    ST_ERR1,
    ST_ERR2
  } slv_state_t;

  // Only NONSEQ and SEQ carry a real transfer.
  function automatic logic trans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_IDLE, HTRANS_BUSY: return 1'b0;
      default:                  return 1'b1;
    endcase
  endfunction

  // Unsupported sizes report 1 byte; the size check flags them separately.
  function automatic logic [2:0] size_bytes(input logic [2:0] hsize);
    case (hsize)
      HSIZE_BYTE: return 3'd1;
      HSIZE_HALF: return 3'd2;
      HSIZE_WORD: return 3'd4;
      default:    return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_addr_check.sv
// Combinational legality check for an AHB transfer into the RAM window.
// AHB_SLV_ALIGN_CHECK_EN additionally rejects misaligned halfword/word accesses.
module ahb_addr_check
  import ahb_pkg::*;
#(
  parameter int RAM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic [ADDR_W-1:0] haddr,
  input  logic [2:0]        hsize,
  output logic              err
);

  logic [ADDR_W:0] last_byte;
  logic            size_err;
  logic            range_err;
  logic            align_err;

  always_comb begin
    size_err  = hsize > HSIZE_WORD;
    // One extra bit so an access running past the top of the address space cannot wrap.
    last_byte = {1'b0, haddr} + (ADDR_W+1)'(size_bytes(hsize)) - (ADDR_W+1)'(1);
    range_err = last_byte >= (ADDR_W+1)'(RAM_BYTES);
`ifdef AHB_SLV_ALIGN_CHECK_EN
    align_err = ((hsize == HSIZE_HALF) && haddr[0]) ||
                ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
`else
    align_err = 1'b0;
`endif
    err = size_err | range_err | align_err;
  end

endmodule

// File: rtl/ahb_ram_slave_if.sv
// AHB-Lite slave front-end for the byte-addressed data RAM: zero-wait writes,
// one-wait reads, two-cycle ERROR for illegal transfers (see AHB_SLV_ALIGN_CHECK_EN).
module ahb_ram_slave_if
  import ahb_pkg::*;
#(
  parameter int RAM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic              hsigned,
  input  logic              hready,
  input  logic [31:0]       hwdata,
  output logic [31:0]       hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              sel_1,
  output logic              rd_en_ram,
  output logic              wr_en_ram,
  output logic [ADDR_W-1:0] address_ram,
  output logic [2:0]        hsize_ram,
  output logic              is_signed,
  output logic [31:0]       wr_data,
  input  logic [31:0]       rd_data
);

  slv_state_t state;
  logic       addr_err;
  logic       can_accept;
  logic       accept;

  ahb_addr_check #(
    .RAM_BYTES (RAM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_addr_check (
    .haddr (haddr),
    .hsize (hsize),
    .err   (addr_err)
  );

  // Bus inputs are only looked at in states that drive hreadyout high.
  assign can_accept = (state == ST_IDLE) || (state == ST_WR) ||
                      (state == ST_RD_DONE) || (state == ST_ERR2);
  assign accept     = can_accept && hsel && hready && trans_active(htrans);

  assign hrdata  = (state == ST_RD_DONE) ? rd_data : 32'h0;
  assign wr_data = wr_en_ram ? hwdata : 32'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      hreadyout   <= 1'b1;
      hresp       <= HRESP_OKAY;
      sel_1       <= 1'b0;
      rd_en_ram   <= 1'b0;
      wr_en_ram   <= 1'b0;
      address_ram <= '0;
      hsize_ram   <= 3'b000;
      is_signed   <= 1'b0;
    end else begin
      case (state)
        ST_RD_ISSUE: begin
          state     <= ST_RD_DONE;
          sel_1     <= 1'b0;
          rd_en_ram <= 1'b0;
          wr_en_ram <= 1'b0;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          sel_1     <= 1'b0;
          rd_en_ram <= 1'b0;
          wr_en_ram <= 1'b0;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        default: begin
          state     <= ST_IDLE;
          sel_1     <= 1'b0;
          rd_en_ram <= 1'b0;
          wr_en_ram <= 1'b0;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
          if (accept) begin
            address_ram <= haddr;
            hsize_ram   <= hsize;
            is_signed   <= hsigned;
            if (addr_err) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= HRESP_ERROR;
            end else if (hwrite) begin
              state     <= ST_WR;
              sel_1     <= 1'b1;
              wr_en_ram <= 1'b1;
            end else begin
              state     <= ST_RD_ISSUE;
              sel_1     <= 1'b1;
              rd_en_ram <= 1'b1;
              hreadyout <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ram_slave_if.sv
// Directed bench for ahb_ram_slave_if with a small byte RAM model behind it.
// Expectations for the offset-2 word read follow AHB_SLV_ALIGN_CHECK_EN.
module tb_ahb_ram_slave_if;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hsigned;
  logic        hready;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic        sel_1;
  logic        rd_en_ram;
  logic        wr_en_ram;
  logic [31:0] address_ram;
  logic [2:0]  hsize_ram;
  logic        is_signed;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Single slave on the bus, so the bus-level HREADY is this slave's own.
  assign hready = hreadyout;

  ahb_ram_slave_if #(
    .RAM_BYTES (64),
    .ADDR_W    (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsel        (hsel),
    .haddr       (haddr),
    .htrans      (htrans),
    .hwrite      (hwrite),
    .hsize       (hsize),
    .hsigned     (hsigned),
    .hready      (hready),
    .hwdata      (hwdata),
    .hrdata      (hrdata),
    .hreadyout   (hreadyout),
    .hresp       (hresp),
    .sel_1       (sel_1),
    .rd_en_ram   (rd_en_ram),
    .wr_en_ram   (wr_en_ram),
    .address_ram (address_ram),
    .hsize_ram   (hsize_ram),
    .is_signed   (is_signed),
    .wr_data     (wr_data),
    .rd_data     (rd_data)
  );

  // RAM model: byte-lane writes, registered little-endian reads with extension.
  logic [7:0] mem [0:63];

  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'b000:  return 1;
      3'b001:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ram_read(input logic [5:0] a, input logic [2:0] s, input logic sg);
    logic [31:0] w;
    w = {mem[a + 6'd3], mem[a + 6'd2], mem[a + 6'd1], mem[a]};
    case (s)
      3'b000:  ram_read = sg ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
      3'b001:  ram_read = sg ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
      default: ram_read = w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      mem[0]  <= 8'hAA;
      mem[1]  <= 8'hBB;
      mem[2]  <= 8'hCC;
      mem[3]  <= 8'hDD;
      mem[4]  <= 8'hEE;
      rd_data <= 32'h0;
    end else begin
      if (wr_en_ram)
        for (int i = 0; i < 4; i++)
          if (i < nbytes(hsize_ram)) mem[address_ram[5:0] + 6'(i)] <= wr_data[8*i +: 8];
      if (rd_en_ram) rd_data <= ram_read(address_ram[5:0], hsize_ram, is_signed);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] s, input logic sg);
    hsel    = 1'b1;
    htrans  = HTRANS_NONSEQ;
    hwrite  = w;
    haddr   = a;
    hsize   = s;
    hsigned = sg;
  endtask

  task automatic bus_idle();
    hsel    = 1'b0;
    htrans  = HTRANS_IDLE;
    hwrite  = 1'b0;
    haddr   = 32'h0;
    hsize   = 3'b000;
    hsigned = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [2:0] s,
                         input logic sg, input logic [31:0] exp);
    addr_phase(1'b0, a, s, sg);
    step();
    bus_idle();
    @(negedge clk);
    check_val({tag, "_wait"}, {31'h0, hreadyout}, 32'h0);
    check_val({tag, "_rdstb"}, {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h6);
    step();
    @(negedge clk);
    check_val({tag, "_data"}, hrdata, exp);
    check_val({tag, "_resp"}, {30'h0, hresp, hreadyout}, 32'h1);
    $display("read  %-10s addr=%0d size=%0d signed=%0d data=%h", tag, a, s, sg, hrdata);
    step();
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    addr_phase(1'b1, a, s, 1'b0);
    step();
    bus_idle();
    hwdata = d;
    @(negedge clk);
    check_val({tag, "_wrstb"}, {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h5);
    check_val({tag, "_ready"}, {30'h0, hresp, hreadyout}, 32'h1);
    $display("write %-10s addr=%0d size=%0d data=%h", tag, a, s, d);
    step();
  endtask

  // Expects {hresp, hreadyout, rd_en_ram, wr_en_ram} = 1000, then 1100, then back to OKAY.
  task automatic do_err(input string tag, input logic w, input logic [31:0] a, input logic [2:0] s);
    addr_phase(w, a, s, 1'b0);
    step();
    bus_idle();
    @(negedge clk);
    check_val({tag, "_err1"}, {28'h0, hresp, hreadyout, rd_en_ram, wr_en_ram}, 32'h8);
    step();
    @(negedge clk);
    check_val({tag, "_err2"}, {28'h0, hresp, hreadyout, rd_en_ram, wr_en_ram}, 32'hC);
    step();
    @(negedge clk);
    check_val({tag, "_idle"}, {28'h0, hresp, hreadyout, rd_en_ram, wr_en_ram}, 32'h4);
    $display("error %-10s addr=%0d size=%0d write=%0d", tag, a, s, w);
    step();
  endtask

  initial begin
    reset  = 1'b0;
    hwdata = 32'h0;
    bus_idle();
    step();
    step();
    @(negedge clk);
    check_val("rst_flags", {26'h0, hreadyout, hresp, sel_1, rd_en_ram, wr_en_ram, is_signed}, 32'h20);
    check_val("rst_hrdata", hrdata, 32'h0);
    check_val("rst_addr", address_ram, 32'h0);
    check_val("rst_size", {29'h0, hsize_ram}, 32'h0);
    $display("reset released");
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    do_read("w0", 32'd0, HSIZE_WORD, 1'b0, 32'hDDCCBBAA);
    do_read("b0s", 32'd0, HSIZE_BYTE, 1'b1, 32'hFFFFFFAA);
    do_read("b0u", 32'd0, HSIZE_BYTE, 1'b0, 32'h000000AA);
    do_read("h0s", 32'd0, HSIZE_HALF, 1'b1, 32'hFFFFBBAA);

    // Halfword write at 8 with a back-to-back halfword read at 8.
    addr_phase(1'b1, 32'd8, HSIZE_HALF, 1'b0);
    step();
    hwdata = 32'h00001234;
    addr_phase(1'b0, 32'd8, HSIZE_HALF, 1'b0);
    @(negedge clk);
    check_val("b2b_wr", {28'h0, hreadyout, sel_1, rd_en_ram, wr_en_ram}, 32'hD);
    step();
    bus_idle();
    @(negedge clk);
    check_val("b2b_wait", {28'h0, hreadyout, sel_1, rd_en_ram, wr_en_ram}, 32'h6);
    step();
    @(negedge clk);
    check_val("b2b_data", hrdata, 32'h00001234);
    $display("b2b   write+read addr=8 data=%h", hrdata);
    step();

    // BUSY with select, and NONSEQ without select: no transfer either way.
    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'd0; hsize = HSIZE_WORD;
    step();
    @(negedge clk);
    check_val("busy", {27'h0, hreadyout, hresp, sel_1, rd_en_ram, wr_en_ram}, 32'h10);
    step();
    hsel = 1'b0; htrans = HTRANS_NONSEQ; hwrite = 1'b1;
    step();
    @(negedge clk);
    check_val("nosel", {27'h0, hreadyout, hresp, sel_1, rd_en_ram, wr_en_ram}, 32'h10);
    $display("idle  busy/nosel no transfer");
    step();
    bus_idle();

    do_err("w62", 1'b0, 32'd62, HSIZE_WORD);
    do_err("sz3", 1'b0, 32'd0, 3'b011);
    do_err("h63wr", 1'b1, 32'd63, HSIZE_HALF);

    do_write("w60", 32'd60, HSIZE_WORD, 32'hCAFEF00D);
    do_read("w60", 32'd60, HSIZE_WORD, 1'b0, 32'hCAFEF00D);
    do_read("b63", 32'd63, HSIZE_BYTE, 1'b0, 32'h000000CA);

`ifdef AHB_SLV_ALIGN_CHECK_EN
    do_err("w2", 1'b0, 32'd2, HSIZE_WORD);
`else
    do_read("w2", 32'd2, HSIZE_WORD, 1'b0, 32'h00EEDDCC);
`endif

    // Reset asserted while the read is in RD_ISSUE.
    addr_phase(1'b0, 32'd0, HSIZE_WORD, 1'b0);
    step();
    bus_idle();
    reset = 1'b0;
    #1;
    check_val("rst_mid", {28'h0, hreadyout, sel_1, rd_en_ram, wr_en_ram}, 32'h8);
    check_val("rst_mid_rdata", hrdata, 32'h0);
    step();
    @(negedge clk);
    check_val("rst_next", {27'h0, hreadyout, hresp, sel_1, rd_en_ram, wr_en_ram}, 32'h10);
    check_val("rst_next_rdata", hrdata, 32'h0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("post_rst_stb", {29'h0, sel_1, rd_en_ram, wr_en_ram}, 32'h0);
    end
    $display("reset mid-read aborted");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
